load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the word-organised, big-endian data memory.
//  Accepts byte/half/word load-store requests from the pipeline and issues word accesses.
//  Sub-word stores run as read-modify-write sequences.
//  Stalls the pipeline via req_ready and returns extended load data with resp_valid.
// PARAMETERS
//  ADDR_W  32  byte-address width (matches `MAX_LENGTH)
//  DATA_W  32  data word width; exactly 32 is supported (4 byte lanes)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  req_valid   in   1       request present; must stay stable until accepted
//  req_ready   out  1       unit idle; request accepted when req_valid && req_ready
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  req_signed  in   1       loads: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, right-justified
//  resp_valid  out  1       one-cycle pulse: access complete
//  resp_rdata  out  DATA_W  extended load data; 0 for stores
//  resp_err    out  1       misaligned-access flag, valid with resp_valid
//  mem_addr    out  ADDR_W  word-aligned address {addr[31:2],2'b00}
//  mem_re      out  1       read strobe; mem_rdata sampled on the same cycle
//  mem_we      out  1       write strobe; memory writes at that posedge
//  mem_wdata   out  DATA_W  full merged word
//  mem_rdata   in   DATA_W  combinational read data from memory
// BEHAVIOUR
//  Reset values: state IDLE, mem_re=0, mem_we=0, resp_valid=0, resp_rdata=0, resp_err=0.
//  req_ready=1 only in IDLE; it is combinational from state.
//  Acceptance latches addr/size/we/signed/wdata. Requests arriving while busy are ignored.
//  FSM states: IDLE, RD, WR, RESP.
//   Load:              IDLE->RD->RESP. In RD: mem_re=1; lane extracted and registered.
//   Word store:        IDLE->WR->RESP. In WR: mem_we=1, mem_wdata=wdata.
//   Sub-word store:    IDLE->RD->WR->RESP. RD captures the word. WR writes the merged word.
//   RESP:              resp_valid=1 for one cycle, then IDLE.
//  Latency, accept edge to resp_valid: loads 2, word store 2, sub-word store 3.
//  Back-to-back requests therefore sustain 1 request per 3 cycles at best.
//  Byte lanes are big-endian: addr[1:0]=0 -> [31:24] ... 3 -> [7:0].
//  Halfwords: addr[1]=0 -> [31:16], 1 -> [15:0].
//  Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; other lanes keep mem_rdata.
//  Extension: sign-extend from bit 7/15 when req_signed=1, else zero-extend.
//  Word loads pass through unchanged.
//  mem_addr is held stable from RD through WR. mem_re and mem_we are never both 1.
//  Reset mid-operation aborts the sequence:
//   - no mem_we is issued for an aborted RD;
//   - no resp_valid is issued.
//  Reset in the WR cycle: the memory's own reset takes precedence.
//  Addresses below 32 read as 0 from memory. A sub-word store there merges with 0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Misaligned requests are half with addr[0]=1, or word with addr[1:0]!=0.
//   - They are accepted and go IDLE->RESP with no mem_re/mem_we.
//   - Response: resp_err=1, resp_rdata=0.
//  MISALIGN_TRAP_EN undefined:
//   - Offending low address bits are ignored (forced aligned).
//   - resp_err is tied to 0.
// STRUCTURE
//  defines.v holds:
//   - `MAX_LENGTH;
//   - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
//   - FSM state encodings LSU_IDLE/LSU_RD/LSU_WR/LSU_RESP.
//  Sub-module lsu_lane_unit is purely combinational: (word, offset, size, signed, wdata) -> extracted, merged.
//  The FSM and registers stay in load_store_unit.
// TESTING
//  1 SW 0x40 0xDEADBEEF, then LW 0x40:
//    -> mem_we pulses with mem_addr 0x40; resp_rdata=0xDEADBEEF; resp_valid 2 cycles after accept.
//  2 Word 0x44=0x11223344; SB 0x45 0xAA:
//    -> mem_re then mem_we, mem_wdata=0x11AA3344.
//    LB 0x45 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
//  3 SH 0x46 0x8001 over 0x11AA3344 -> 0x11AA8001.
//    LH 0x46 signed -> 0xFFFF8001; unsigned -> 0x00008001.
//  4 Two requests, req_valid held high:
//    -> req_ready low during RD/WR/RESP; second accepted only on return to IDLE; both responses in order.
//  5 Reset asserted while in RD of SB 0x48:
//    -> no mem_we, no resp_valid; next cycle IDLE with req_ready=1; word 0x48 unchanged.
//  6 LW 0x42, with MISALIGN_TRAP_EN:
//    -> resp_err=1, rdata=0, no mem_re.
//    Without MISALIGN_TRAP_EN -> mem_addr 0x40, normal load.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: address width, access size codes,
// controller state type and a size helper.
package load_store_unit_pkg;

    localparam int MAX_LENGTH = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_RD,
        LSU_WR,
        LSU_RESP
    } lsu_state_e;

    // The reserved size code 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Combinational big-endian lane logic: extracts and extends a load lane, and merges
// store data into the addressed lane of a memory word.
module lsu_lane_unit
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        extracted = '0;
        merged    = word;
        byte_val  = '0;
        half_val  = '0;
        if (is_word(size)) begin
            extracted = word;
            merged    = wdata;
        end else if (size == SZ_HALF) begin
            // offset[0] is ignored so a misaligned half is forced aligned.
            if (offset[1]) begin
                half_val      = word[15:0];
                merged[15:0]  = wdata[15:0];
            end else begin
                half_val      = word[31:16];
                merged[31:16] = wdata[15:0];
            end
            extracted = {{16{is_signed & half_val[15]}}, half_val};
        end else begin
            case (offset)
                2'd0: begin byte_val = word[31:24]; merged[31:24] = wdata[7:0]; end
                2'd1: begin byte_val = word[23:16]; merged[23:16] = wdata[7:0]; end
                2'd2: begin byte_val = word[15:8];  merged[15:8]  = wdata[7:0]; end
                default: begin byte_val = word[7:0]; merged[7:0] = wdata[7:0]; end
            endcase
            extracted = {{24{is_signed & byte_val[7]}}, byte_val};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-organised big-endian memory; sub-word
// stores run as read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = MAX_LENGTH,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state, state_next;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        size_r;
    logic              we_r;
    logic              signed_r;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] lane_extracted;
    logic [DATA_W-1:0] lane_merged;
    logic              accept;
    logic              misaligned;

    assign accept = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    logic err_r;

    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign resp_err   = err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign resp_err   = 1'b0;
`endif

    lsu_lane_unit u_lane (
        .word      (mem_rdata),
        .offset    (addr_r[1:0]),
        .size      (size_r),
        .is_signed (signed_r),
        .wdata     (wr_word),
        .extracted (lane_extracted),
        .merged    (lane_merged)
    );

    // wr_word carries the store data until RD, then the merged word for WR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LSU_IDLE;
            addr_r   <= '0;
            size_r   <= '0;
            we_r     <= 1'b0;
            signed_r <= 1'b0;
            wr_word  <= '0;
            rdata_r  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_r   <= req_addr;
                size_r   <= req_size;
                we_r     <= req_we;
                signed_r <= req_signed;
                wr_word  <= req_wdata;
                rdata_r  <= '0;
            end
            if (state == LSU_RD) begin
                if (we_r) begin
                    wr_word <= lane_merged;
                end else begin
                    rdata_r <= lane_extracted;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_next = LSU_RESP;
                    end else if (req_we && is_word(req_size)) begin
                        state_next = LSU_WR;
                    end else begin
                        state_next = LSU_RD;
                    end
                end
            end
            LSU_RD:   state_next = we_r ? LSU_WR : LSU_RESP;
            LSU_WR:   state_next = LSU_RESP;
            default:  state_next = LSU_IDLE;
        endcase
    end

    assign req_ready  = (state == LSU_IDLE);
    assign mem_re     = (state == LSU_RD);
    assign mem_we     = (state == LSU_WR);
    assign resp_valid = (state == LSU_RESP);
    assign mem_addr   = {addr_r[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wr_word;
    assign resp_rdata = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// word-array memory reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    int          re_cnt, we_cnt, addr_bad, both_cnt;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory seen by the DUT: low 32 bytes read as zero, writes ignored under reset.
    always_comb mem_rdata = (mem_addr < 32) ? 32'h0 : mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we && !reset && mem_addr >= 32) mem[mem_addr[7:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
        if (mem_re && mem_we) both_cnt++;
        if ((mem_re || mem_we) && mem_addr != exp_addr) addr_bad++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a < 32) ? 32'h0 : ref_mem[a[7:2]];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size, input logic sgn);
        logic [31:0] w, v;
        int off;
        w = model_read(a);
        off = int'(a % 4);
        if (size == 2'd0) begin
            v = (w >> (8 * (3 - off))) & 32'hff;
            if (sgn && v >= 128) v = v | 32'hffffff00;
        end else if (size == 2'd1) begin
            v = (w >> ((off >= 2) ? 0 : 16)) & 32'hffff;
            if (sgn && v >= 32768) v = v | 32'hffff0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] old, mask, nw;
        int sh;
        old = model_read(a);
        if (size[1]) begin
            nw = wd;
        end else if (size == 2'd1) begin
            sh = (a % 4 >= 2) ? 0 : 16;
            mask = 32'hffff << sh;
            nw = (old & ~mask) | ((wd & 32'hffff) << sh);
        end else begin
            sh = 8 * (3 - int'(a % 4));
            mask = 32'hff << sh;
            nw = (old & ~mask) | ((wd & 32'hff) << sh);
        end
        if (a >= 32) ref_mem[a[7:2]] = nw;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        mis, got;
        logic [31:0] ea, exp_rd;
        int          exp_lat, exp_re, exp_we, lat, guard;
`ifdef MISALIGN_TRAP_EN
        mis = (size == 2'd1 && a[0]) || (size[1] && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        ea = a;
        if (size == 2'd1) ea[0] = 1'b0;
        if (size[1]) ea[1:0] = 2'b00;
        exp_rd = 32'h0;
        if (!mis && !we) exp_rd = model_load(ea, size, sgn);
        if (!mis && we) model_store(ea, size, wd);
        exp_lat = mis ? 1 : (we && !size[1]) ? 3 : 2;
        exp_re  = (!mis && (!we || !size[1])) ? 1 : 0;
        exp_we  = (!mis && we) ? 1 : 0;

        @(negedge clk);
        exp_addr = {a[31:2], 2'b00};
        re_cnt = 0; we_cnt = 0; addr_bad = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (resp_valid) got = 1'b1;
        end
        rd = resp_rdata;
        check("resp_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", 32'(resp_err), 32'(mis));
        check("mem_re_count", 32'(re_cnt), 32'(exp_re));
        check("mem_we_count", 32'(we_cnt), 32'(exp_we));
        check("mem_addr_stable", 32'(addr_bad), 32'd0);
    endtask

    logic [31:0] rd, exp_a, exp_b;
    int          we_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        both_cnt = 0; exp_addr = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;

        // 1: word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd);
        check("t1_lw", rd, 32'hDEADBEEF);

        // 2: byte store merge and byte loads
        do_req(1'b1, 2'd2, 1'b0, 32'h44, 32'h11223344, rd);
        do_req(1'b1, 2'd0, 1'b0, 32'h45, 32'h000000AA, rd);
        check("t2_merged_word", mem[17], 32'h11AA3344);
        do_req(1'b0, 2'd0, 1'b1, 32'h45, 32'h0, rd);
        check("t2_lb_signed", rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b0, 32'h45, 32'h0, rd);
        check("t2_lb_unsigned", rd, 32'h000000AA);

        // 3: half store merge and half loads
        do_req(1'b1, 2'd1, 1'b0, 32'h46, 32'h00008001, rd);
        check("t3_merged_word", mem[17], 32'h11AA8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h46, 32'h0, rd);
        check("t3_lh_signed", rd, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, rd);
        check("t3_lh_unsigned", rd, 32'h00008001);

        // 4: two loads with req_valid held high throughout
        exp_a = model_load(32'h40, 2'd2, 1'b0);
        exp_b = model_load(32'h44, 2'd2, 1'b0);
        @(negedge clk);
        exp_addr = 32'h40;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(negedge clk);
        check("t4_ready_rd", 32'(req_ready), 32'd0);
        exp_addr = 32'h44;
        req_addr = 32'h44;
        @(negedge clk);
        check("t4_ready_resp", 32'(req_ready), 32'd0);
        check("t4_resp_a_valid", 32'(resp_valid), 32'd1);
        check("t4_resp_a_data", resp_rdata, exp_a);
        @(negedge clk);
        check("t4_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("t4_ready_rd2", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("t4_resp_b_valid", 32'(resp_valid), 32'd1);
        check("t4_resp_b_data", resp_rdata, exp_b);

        // 5: reset during the RD cycle of a byte store
        do_req(1'b1, 2'd2, 1'b0, 32'h48, 32'hCAFEF00D, rd);
        @(negedge clk);
        exp_addr = 32'h48;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h48; req_wdata = 32'h55;
        @(posedge clk);
        we_seen = we_cnt;
        @(negedge clk);
        check("t5_in_rd", 32'(mem_re), 32'd1);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_no_we", 32'(mem_we), 32'd0);
        check("t5_no_resp", 32'(resp_valid), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_resp_after", 32'(resp_valid), 32'd0);
        check("t5_we_never", 32'(we_cnt - we_seen), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, rd);
        check("t5_word_kept", rd, 32'hCAFEF00D);

        // 6: misaligned word load
        do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, rd);

        // Random traffic, including the zero-reading low region
        for (int n = 0; n < 150; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom, rd);
        end

        for (int i = 8; i < 64; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        check("re_we_exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
